uart_out_buffer: RTL and testbench

UART_OUT_BUFFER -- requirements
Module: uart_out_buffer

---
 rtl/uart_out_buffer.sv | 187 ++++++++++++++++++
 tb/tb_uart_out_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_out_buffer.sv
// uart_out_buffer
//   A byte FIFO feeding an 8N1 UART serializer. The core pushes bytes with
//   wr_en/wr_data. When the FIFO is full, a write is dropped and the sticky
//   overflow flag is set. The serializer pops one byte whenever it is idle and
//   the FIFO is non-empty, then shifts it out LSB first.
//
// Ports
//   clk      : single clock, rising edge
//   rstn     : asynchronous active-low reset
//   wr_en    : push request
//   wr_data  : byte to push
//   full     : FIFO holds DEPTH entries (registered)
//   empty    : FIFO holds no entries (registered)
//   count    : FIFO occupancy, DEPTH_LOG2+1 bits
//   overflow : sticky, a write was dropped since reset
//   busy     : serializer is not idle
//   txd      : serial line, idle high, registered
//
// Serializer states
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | line high, pops the head byte when FIFO non-empty
//   S_START | start bit (low) for one bit period
//   S_DATA  | 8 data bits, LSB first, one bit period each
//   S_STOP  | stop bit (high) for one bit period
module uart_out_buffer #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int DEPTH_LOG2       = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  busy,
    output logic                  txd
);

    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int BIT_PERIOD = 2 * CLK_PER_HALF_BIT;
    localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(BIT_PERIOD - 1);
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [DEPTH_LOG2:0]   count_n;
    logic                  wr_acc;
    logic                  pop;

    state_t                state;
    state_t                state_n;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_cnt_n;
    logic [2:0]            bit_idx;
    logic [2:0]            bit_idx_n;
    logic [7:0]            shreg;
    logic                  txd_n;

    // full is the registered flag, so a same-cycle pop never frees a slot
    // for a write that arrives while full.
    assign wr_acc = wr_en & ~full;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[tail] <= wr_data;
        end
    end

    always_comb begin
        count_n = count;
        case ({wr_acc, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count_n;
            full  <= (count_n == COUNT_FULL);
            empty <= (count_n == '0);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // txd_n is derived from the current state and registered, so the line
    // trails the state by one cycle. Each level still lasts exactly one bit
    // period, and the single IDLE cycle appears as one extra high cycle
    // between frames.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bit_idx_n = bit_idx;
        pop       = 1'b0;
        txd_n     = 1'b1;
        case (state)
            S_IDLE: begin
                bit_cnt_n = '0;
                bit_idx_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                txd_n = 1'b0;
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_n = '0;
                    state_n   = S_DATA;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            S_DATA: begin
                txd_n = shreg[bit_idx];
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_n = '0;
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_n = '0;
                    state_n   = S_IDLE;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            bit_idx <= bit_idx_n;
            txd     <= txd_n;
            if (pop) begin
                shreg <= mem[head];
            end
        end
    end

endmodule

// File: tb/tb_uart_out_buffer.sv
// tb_uart_out_buffer
//   Random and directed stimulus for uart_out_buffer with a bit period of
//   8 cycles. The driver keeps a queue model of the FIFO and a frame timer for
//   the serializer. Every accepted byte is pushed to an expected queue. An
//   independent UART receiver decodes txd and pops that queue per frame.
module tb_uart_out_buffer;

    localparam int HALF  = 4;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 80;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         wr_en = 1'b0;
    logic [7:0]   wr_data = 8'h00;
    logic         full, empty, overflow, busy, txd;
    logic [DL2:0] count;

    uart_out_buffer #(.CLK_PER_HALF_BIT(HALF), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .busy(busy), .txd(txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         fall_q[$];
    int         ser_left = 0;
    bit         ovf_m = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int last_fall(input int back);
        if (fall_q.size() > back) return fall_q[fall_q.size() - 1 - back];
        return -1000;
    endfunction

    // One clock of stimulus: the model advances on the same edge as the DUT.
    task automatic cycle(input logic we, input logic [7:0] d);
        bit full_m, pop_m;
        @(negedge clk);
        wr_en   = we;
        wr_data = d;
        full_m = (mq.size() == DEPTH);
        pop_m  = (ser_left == 0) && (mq.size() > 0);
        if (pop_m) begin
            void'(mq.pop_front());
            ser_left = FRAME;
        end else if (ser_left > 0) begin
            ser_left--;
        end
        if (we) begin
            if (!full_m) begin
                mq.push_back(d);
                exp_q.push_back(d);
            end else begin
                ovf_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("count", int'(count), mq.size());
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("overflow", int'(overflow), int'(ovf_m));
        chk("busy", int'(busy), int'(ser_left > 0));
    endtask

    task automatic drain();
        int n = 0;
        while ((ser_left > 0 || mq.size() > 0) && n < 3000) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        repeat (4) cycle(1'b0, 8'h00);
        chk("drain_all_received", exp_q.size(), 0);
    endtask

    // Reference receiver: sample every cycle of a frame on the falling edge,
    // require each bit level to be constant for 8 cycles, then decode.
    initial begin
        logic       s [80];
        logic [7:0] b;
        bit         aborted;
        bit         lvl_ok;
        forever begin
            @(negedge clk);
            if (rstn && txd === 1'b0) begin
                fall_q.push_back(cyc);
                aborted = 1'b0;
                s[0] = txd;
                for (int i = 1; i < 80; i++) begin
                    @(negedge clk);
                    if (!rstn) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = txd;
                end
                if (!aborted) begin
                    lvl_ok = 1'b1;
                    for (int bi = 0; bi < 10; bi++)
                        for (int k = 1; k < 8; k++)
                            if (s[bi*8+k] !== s[bi*8]) lvl_ok = 1'b0;
                    chk("rx_bit_timing", int'(lvl_ok), 1);
                    chk("rx_stop_bit", int'(s[72]), 1);
                    for (int bi = 0; bi < 8; bi++) b[bi] = s[8 + bi*8];
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: got byte 0x%02h, expected no frame", b);
                    end else begin
                        chk("rx_data", int'(b), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        logic [7:0] bv;

        // Reset values, asynchronously.
        #2 rstn = 1'b0;
        #1;
        chk("rst_txd", int'(txd), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;

        // Single byte 0x99 and start latency.
        cycle(1'b1, 8'h99);
        w = cyc;
        drain();
        chk("latency_0x99", last_fall(0) - w, 2);

        // Two back-to-back bytes: exactly one idle-high cycle between frames.
        cycle(1'b1, 8'h66);
        cycle(1'b1, 8'hA5);
        drain();
        chk("frame_gap", last_fall(0) - last_fall(1), FRAME + 1);

        // Stall behind one frame, then 17 writes: the last is dropped. Keep
        // writing through the pop cycle of a full FIFO.
        cycle(1'b1, 8'hC3);
        repeat (3) cycle(1'b0, 8'h00);
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(16 + i));
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), DEPTH);
        chk("fill_overflow", int'(overflow), 1);
        for (int i = 0; i < 90; i++) cycle(1'b1, 8'($urandom));
        drain();

        // Reset during data bit 3, with overflow set beforehand.
        bv = 8'h52;
        cycle(1'b1, bv);
        for (int i = 0; i < 18; i++) cycle(1'b1, 8'(8'h80 + i));
        repeat (17) cycle(1'b0, 8'h00);
        chk("pre_rst_bit3", int'(txd), int'(bv[3]));
        chk("pre_rst_overflow", int'(overflow), 1);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_txd", int'(txd), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_overflow", int'(overflow), 0);
        mq.delete();
        exp_q.delete();
        ser_left = 0;
        ovf_m = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        cycle(1'b1, 8'h01);
        w = cyc;
        drain();
        chk("latency_after_rst", last_fall(0) - w, 2);

        // 40 random bytes below line rate: pointers wrap, no overflow.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'($urandom));
            repeat ($urandom_range(70, 110)) cycle(1'b0, 8'h00);
        end
        drain();
        chk("random_no_overflow", int'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
